fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues word-aligned fetch requests under a credit limit,
// buffers in-order responses with their addresses, and flushes in-flight requests
// when the pipeline redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   discard_q;
  logic [CW-1:0]   buf_count_q;
  logic [PW-1:0]   aq_wr_ptr_q;
  logic [PW-1:0]   aq_rd_ptr_q;
  logic [PW-1:0]   buf_wr_ptr_q;
  logic [PW-1:0]   buf_rd_ptr_q;
  logic [31:0]     aq_addr_q  [DEPTH];
  logic [31:0]     buf_addr_q [DEPTH];
  logic [31:0]     buf_data_q [DEPTH];

  logic            issue;
  logic            resp_ok;
  logic            redirect;
  logic            pop;
  logic            buf_push;
  logic [CW:0]     occupancy;
  logic [CW-1:0]   drain;
  logic            unused_redirect_lsbs;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Request credit, handshakes and flush bookkeeping derived from current state.
  always_comb begin
    occupancy      = {1'b0, buf_count_q} + {1'b0, outstanding_q};
    imem_req_valid = (state_q == StRun) && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
    imem_req_addr  = pc_q;
    issue          = imem_req_valid && imem_req_ready;
    // A response with nothing in flight is a protocol error and is ignored.
    resp_ok        = imem_resp_valid && (outstanding_q != '0);
    redirect       = redirect_valid && (state_q != StIdle);
    out_valid      = (state_q == StRun) && (buf_count_q != '0);
    pop            = out_valid && out_ready;
    buf_push       = resp_ok && (state_q == StRun) && !redirect;
    // In-flight requests left to drop after a redirect in this cycle.
    drain          = outstanding_q - CW'(resp_ok);
    inst           = buf_data_q[buf_rd_ptr_q];
    inst_addr      = buf_addr_q[buf_rd_ptr_q];
  end

  assign unused_redirect_lsbs = ^redirect_addr[1:0];

  // Control FSM: state, pc, credit counters and queue pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      buf_count_q   <= '0;
      aq_wr_ptr_q   <= '0;
      aq_rd_ptr_q   <= '0;
      buf_wr_ptr_q  <= '0;
      buf_rd_ptr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StRun;
        end
        StRun, StFlush: begin
          if (redirect) begin
            // Outstanding keeps counting the doomed requests so credit stays exact.
            pc_q          <= {redirect_addr[31:2], 2'b00};
            outstanding_q <= drain;
            discard_q     <= drain;
            buf_count_q   <= '0;
            aq_wr_ptr_q   <= '0;
            aq_rd_ptr_q   <= '0;
            buf_wr_ptr_q  <= '0;
            buf_rd_ptr_q  <= '0;
            state_q       <= (drain != '0) ? StFlush : StRun;
          end else if (state_q == StRun) begin
            if (issue) begin
              pc_q        <= pc_q + 32'd4;
              aq_wr_ptr_q <= ptr_inc(aq_wr_ptr_q);
            end
            if (buf_push) begin
              aq_rd_ptr_q  <= ptr_inc(aq_rd_ptr_q);
              buf_wr_ptr_q <= ptr_inc(buf_wr_ptr_q);
            end
            if (pop) begin
              buf_rd_ptr_q <= ptr_inc(buf_rd_ptr_q);
            end
            outstanding_q <= outstanding_q + CW'(issue) - CW'(resp_ok);
            buf_count_q   <= buf_count_q + CW'(buf_push) - CW'(pop);
          end else if (resp_ok) begin
            outstanding_q <= outstanding_q - CW'(1);
            discard_q     <= discard_q - CW'(1);
            if (discard_q == CW'(1)) begin
              state_q <= StRun;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Address queue and instruction buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        aq_addr_q[i]  <= '0;
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      if (issue) begin
        aq_addr_q[aq_wr_ptr_q] <= pc_q;
      end
      if (buf_push) begin
        buf_addr_q[buf_wr_ptr_q] <= aq_addr_q[aq_rd_ptr_q];
        buf_data_q[buf_wr_ptr_q] <= imem_resp_data;
      end
    end
  end

endmodule
